// File: rtl/router_sync_n_pkg.sv
// Shared constants and helpers for the router/FIFO synchroniser.
package router_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int TIMEOUT_DEF   = 30;

  typedef logic [NUM_PORTS_DEF-1:0] port_vec_t;

  // Sized for the widest supported configuration (16 ports); callers slice.
  function automatic logic [15:0] onehot(input logic [3:0] addr);
    onehot = 16'(1) << addr;
  endfunction
endpackage

// File: rtl/router_sync_n_if.sv
// Bus between the router FSM / FIFO bank and the synchroniser.
interface router_sync_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 2
);
  logic [ADDR_W-1:0]    data_in;
  logic                 detect_add;
  logic                 write_enb_reg;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] flag_clr;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic [NUM_PORTS-1:0] timeout_flag;
  logic                 addr_err;

  modport master (
    output data_in, detect_add, write_enb_reg, full, empty, read_enb, flag_clr,
    input  write_enb, fifo_full, vld_out, soft_reset, timeout_flag, addr_err
  );

  modport slave (
    input  data_in, detect_add, write_enb_reg, full, empty, read_enb, flag_clr,
    output write_enb, fifo_full, vld_out, soft_reset, timeout_flag, addr_err
  );
endinterface

// File: rtl/router_sync_n_wdog.sv
// Per-port read watchdog: soft-resets a FIFO holding data nobody reads.
module router_wdog #(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  input  logic clr,
  output logic soft_reset,
  output logic flag
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_q, soft_d;
  logic             flag_q, flag_d;
  logic             stall;

  always_comb begin
    cnt_d  = '0;
    soft_d = 1'b0;
    flag_d = flag_q & ~clr;
    stall  = vld & ~rd;
    if (stall) begin
      // Firing restarts the count, so back-to-back pulses are impossible.
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        soft_d = 1'b1;
        flag_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      soft_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      soft_q <= soft_d;
      flag_q <= flag_d;
    end
  end

  assign soft_reset = soft_q;
  assign flag       = flag_q;
endmodule

// File: rtl/router_sync_n.sv
// Router-to-FIFO synchroniser: address latch, write steering, full return,
// per-port valid and read watchdogs.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = 5
) (
  input logic            clk,
  input logic            resetn,
  router_sync_n_if.slave bus
);
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 addr_ok_q, addr_ok_d;
  logic                 addr_err_q, addr_err_d;
  logic                 in_ok;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_ok;
  logic [15:0]          oh;
  logic [NUM_PORTS-1:0] sel_vec;
  logic [NUM_PORTS-1:0] soft_w, flag_w;

  always_comb begin
    in_ok      = (int'(bus.data_in) < NUM_PORTS);
    addr_d     = addr_q;
    addr_ok_d  = addr_ok_q;
    addr_err_d = 1'b0;
    if (bus.detect_add) begin
      addr_d     = bus.data_in;
      addr_ok_d  = in_ok;
      addr_err_d = ~in_ok;
    end
    // Header byte bypasses the latch so the same-cycle write is steered.
    sel_addr = bus.detect_add ? bus.data_in : addr_q;
    sel_ok   = bus.detect_add ? in_ok : addr_ok_q;
    oh       = onehot(4'(sel_addr));
    sel_vec  = sel_ok ? oh[NUM_PORTS-1:0] : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_ok_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_ok_q  <= addr_ok_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.write_enb = bus.write_enb_reg ? sel_vec : '0;
  assign bus.fifo_full = |(bus.full & sel_vec);
  assign bus.vld_out   = ~bus.empty;
  assign bus.addr_err  = addr_err_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdog
    router_wdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wdog (
      .clk       (clk),
      .resetn    (resetn),
      .vld       (~bus.empty[i]),
      .rd        (bus.read_enb[i]),
      .clr       (bus.flag_clr[i]),
      .soft_reset(soft_w[i]),
      .flag      (flag_w[i])
    );
  end

  assign bus.soft_reset   = soft_w;
  assign bus.timeout_flag = flag_w;
endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench: a 4-port and a 3-port instance share clock and reset.
module tb_router_sync_n;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  router_sync_n_if #(.NUM_PORTS(4), .ADDR_W(2)) a ();
  router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2)) b ();

  router_sync_n #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)) dut_a (
    .clk(clk), .resetn(resetn), .bus(a));
  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)) dut_b (
    .clk(clk), .resetn(resetn), .bus(b));

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    a.data_in = 0; a.detect_add = 0; a.write_enb_reg = 1; a.full = '1;
    a.empty = 4'b0101; a.read_enb = 0; a.flag_clr = 0;
    b.data_in = 0; b.detect_add = 0; b.write_enb_reg = 0; b.full = 0;
    b.empty = '1; b.read_enb = 0; b.flag_clr = 0;
    resetn = 0;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'ha);
    step(); step();
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL rst_we got=%h exp=%h", a.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.fifo_full) !== e) begin n_fail++; $display("FAIL rst_ff got=%h exp=%h", a.fifo_full, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL rst_soft got=%h exp=%h", a.soft_reset, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.timeout_flag) !== e) begin n_fail++; $display("FAIL rst_flag got=%h exp=%h", a.timeout_flag, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.addr_err) !== e) begin n_fail++; $display("FAIL rst_err got=%h exp=%h", a.addr_err, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.vld_out) !== e) begin n_fail++; $display("FAIL vld_out got=%h exp=%h", a.vld_out, e); end
    a.empty = '1; a.write_enb_reg = 0; a.full = 0;
    resetn = 1;
    step();
  endtask

  task automatic test_steer();
    logic [15:0] e;
    a.detect_add = 1; a.data_in = 2;
    step();
    a.detect_add = 0; a.data_in = 0; a.write_enb_reg = 1; a.full = 4'b0100;
    exp_q.push_back(16'h4); exp_q.push_back(16'h1); exp_q.push_back(16'h0);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL steer_we got=%h exp=%h", a.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.fifo_full) !== e) begin n_fail++; $display("FAIL steer_ff got=%h exp=%h", a.fifo_full, e); end
    a.full = 4'b1011;
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.fifo_full) !== e) begin n_fail++; $display("FAIL steer_ff_other got=%h exp=%h", a.fifo_full, e); end
    a.write_enb_reg = 0; a.full = 0;
    step();
  endtask

  task automatic test_bypass();
    logic [15:0] e;
    a.detect_add = 1; a.data_in = 3; a.write_enb_reg = 1;
    exp_q.push_back(16'h8); exp_q.push_back(16'h8); exp_q.push_back(16'h0);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL bypass_we got=%h exp=%h", a.write_enb, e); end
    step();
    a.detect_add = 0; a.data_in = 1;
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL latched_we got=%h exp=%h", a.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.addr_err) !== e) begin n_fail++; $display("FAIL valid_no_err got=%h exp=%h", a.addr_err, e); end
    a.write_enb_reg = 0;
    step();
  endtask

  task automatic test_addr_err();
    logic [15:0] e;
    b.detect_add = 1; b.data_in = 1; b.write_enb_reg = 1; b.full = '1;
    step();
    b.data_in = 3;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(b.write_enb) !== e) begin n_fail++; $display("FAIL oor_we_bypass got=%h exp=%h", b.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(b.fifo_full) !== e) begin n_fail++; $display("FAIL oor_ff_bypass got=%h exp=%h", b.fifo_full, e); end
    step();
    b.detect_add = 0; b.data_in = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(k == 0 ? 16'h1 : 16'h0);
      exp_q.push_back(16'h0); exp_q.push_back(16'h0);
      #1;
      e = exp_q.pop_front(); n_chk++;
      if (16'(b.addr_err) !== e) begin n_fail++; $display("FAIL oor_err[%0d] got=%h exp=%h", k, b.addr_err, e); end
      e = exp_q.pop_front(); n_chk++;
      if (16'(b.write_enb) !== e) begin n_fail++; $display("FAIL oor_we[%0d] got=%h exp=%h", k, b.write_enb, e); end
      e = exp_q.pop_front(); n_chk++;
      if (16'(b.fifo_full) !== e) begin n_fail++; $display("FAIL oor_ff[%0d] got=%h exp=%h", k, b.fifo_full, e); end
      step();
    end
    b.detect_add = 1; b.data_in = 2;
    step();
    b.detect_add = 0;
    exp_q.push_back(16'h4); exp_q.push_back(16'h1);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(b.write_enb) !== e) begin n_fail++; $display("FAIL recover_we got=%h exp=%h", b.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(b.fifo_full) !== e) begin n_fail++; $display("FAIL recover_ff got=%h exp=%h", b.fifo_full, e); end
    b.write_enb_reg = 0; b.full = 0;
    step();
  endtask

  task automatic test_wdog();
    logic [15:0] e;
    a.empty = 4'b1101; a.read_enb = 0;
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back(k == 30 ? 16'h2 : 16'h0);
      step();
      e = exp_q.pop_front(); n_chk++;
      if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL fire_soft[%0d] got=%h exp=%h", k, a.soft_reset, e); end
    end
    exp_q.push_back(16'h2);
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.timeout_flag) !== e) begin n_fail++; $display("FAIL fire_flag got=%h exp=%h", a.timeout_flag, e); end
    a.empty = '1;
    step();
    a.empty = 4'b1101;
    for (int k = 1; k <= 29; k++) step();
    a.read_enb = 4'b0010;
    exp_q.push_back(16'h0);
    step();
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL term_read_soft got=%h exp=%h", a.soft_reset, e); end
    a.read_enb = 0;
    for (int k = 1; k <= 30; k++) begin
      exp_q.push_back(k == 30 ? 16'h2 : 16'h0);
      step();
      e = exp_q.pop_front(); n_chk++;
      if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL restart_soft[%0d] got=%h exp=%h", k, a.soft_reset, e); end
    end
    a.empty = '1;
    step();
  endtask

  task automatic test_flag_clr();
    logic [15:0] e;
    a.flag_clr = 4'b0010;
    exp_q.push_back(16'h0);
    step();
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.timeout_flag) !== e) begin n_fail++; $display("FAIL w1c_flag got=%h exp=%h", a.timeout_flag, e); end
    a.flag_clr = 0; a.empty = 4'b1001;
    for (int k = 1; k <= 29; k++) step();
    a.flag_clr = 4'b0110;
    exp_q.push_back(16'h6); exp_q.push_back(16'h6);
    step();
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL dual_soft got=%h exp=%h", a.soft_reset, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.timeout_flag) !== e) begin n_fail++; $display("FAIL set_wins_flag got=%h exp=%h", a.timeout_flag, e); end
    a.flag_clr = 0; a.empty = '1;
    exp_q.push_back(16'h0);
    step();
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL dual_soft_end got=%h exp=%h", a.soft_reset, e); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    a.detect_add = 1; a.data_in = 1;
    step();
    a.detect_add = 0; a.write_enb_reg = 1; a.empty = 4'b1101;
    for (int k = 1; k <= 20; k++) step();
    #2;
    resetn = 0;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.timeout_flag) !== e) begin n_fail++; $display("FAIL async_flag got=%h exp=%h", a.timeout_flag, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL async_we got=%h exp=%h", a.write_enb, e); end
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL async_soft got=%h exp=%h", a.soft_reset, e); end
    step();
    resetn = 1;
    for (int k = 1; k <= 30; k++) begin
      exp_q.push_back(k == 30 ? 16'h2 : 16'h0);
      step();
      e = exp_q.pop_front(); n_chk++;
      if (16'(a.soft_reset) !== e) begin n_fail++; $display("FAIL post_rst_soft[%0d] got=%h exp=%h", k, a.soft_reset, e); end
    end
    exp_q.push_back(16'h0);
    e = exp_q.pop_front(); n_chk++;
    if (16'(a.write_enb) !== e) begin n_fail++; $display("FAIL post_rst_we got=%h exp=%h", a.write_enb, e); end
    a.empty = '1; a.write_enb_reg = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_steer();
    test_bypass();
    test_addr_err();
    test_wdog();
    test_flag_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
